// File: rtl/text_column_streamer.sv
// text_column_streamer: line buffer plus 5x7 font, streamed as
// SSD1306 page columns over a valid/ready link.
module text_column_streamer #(
    parameter int NUM_CHARS = 16,
    parameter int GAP_W = 1,
    localparam int AW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic          invert,
    output logic [7:0]    col_data,
    output logic          col_valid,
    input  logic          col_ready,
    output logic          col_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;

    localparam logic [2:0]    COL_END  = 3'(4 + GAP_W);
    localparam logic [AW-1:0] CHAR_END = AW'(NUM_CHARS - 1);
    localparam logic [AW:0]   SLOTS    = (AW + 1)'(NUM_CHARS);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] char_idx;
    logic [AW-1:0] char_idx_nx;
    logic [2:0]    col_idx;
    logic [2:0]    col_idx_nx;
    logic [7:0]    char_reg;
    logic [7:0]    char_nx;
    logic          inv_reg;
    logic          inv_nx;
    logic [7:0]    glyph;
    logic [7:0]    text_buf [NUM_CHARS];

    function automatic logic [39:0] font_row(input logic [5:0] i);
        logic [39:0] r;
        case (i)
            6'h00: r = 40'h0000000000;
            6'h01: r = 40'h00005F0000;
            6'h02: r = 40'h0007000700;
            6'h03: r = 40'h147F147F14;
            6'h04: r = 40'h242A7F2A12;
            6'h05: r = 40'h2313086462;
            6'h06: r = 40'h3649562050;
            6'h07: r = 40'h0008070300;
            6'h08: r = 40'h001C224100;
            6'h09: r = 40'h0041221C00;
            6'h0A: r = 40'h2A1C7F1C2A;
            6'h0B: r = 40'h08083E0808;
            6'h0C: r = 40'h0080703000;
            6'h0D: r = 40'h0808080808;
            6'h0E: r = 40'h0000606000;
            6'h0F: r = 40'h2010080402;
            6'h10: r = 40'h3E5149453E;
            6'h11: r = 40'h00427F4000;
            6'h12: r = 40'h7249494946;
            6'h13: r = 40'h2141494D33;
            6'h14: r = 40'h1814127F10;
            6'h15: r = 40'h2745454539;
            6'h16: r = 40'h3C4A494931;
            6'h17: r = 40'h4121110907;
            6'h18: r = 40'h3649494936;
            6'h19: r = 40'h464949291E;
            6'h1A: r = 40'h0000140000;
            6'h1B: r = 40'h0040340000;
            6'h1C: r = 40'h0008142241;
            6'h1D: r = 40'h1414141414;
            6'h1E: r = 40'h0041221408;
            6'h1F: r = 40'h0201590906;
            6'h20: r = 40'h3E415D594E;
            6'h21: r = 40'h7C1211127C;
            6'h22: r = 40'h7F49494936;
            6'h23: r = 40'h3E41414122;
            6'h24: r = 40'h7F4141413E;
            6'h25: r = 40'h7F49494941;
            6'h26: r = 40'h7F09090901;
            6'h27: r = 40'h3E41415173;
            6'h28: r = 40'h7F0808087F;
            6'h29: r = 40'h00417F4100;
            6'h2A: r = 40'h2040413F01;
            6'h2B: r = 40'h7F08142241;
            6'h2C: r = 40'h7F40404040;
            6'h2D: r = 40'h7F021C027F;
            6'h2E: r = 40'h7F0408107F;
            6'h2F: r = 40'h3E4141413E;
            6'h30: r = 40'h7F09090906;
            6'h31: r = 40'h3E4151215E;
            6'h32: r = 40'h7F09192946;
            6'h33: r = 40'h2649494932;
            6'h34: r = 40'h03017F0103;
            6'h35: r = 40'h3F4040403F;
            6'h36: r = 40'h1F2040201F;
            6'h37: r = 40'h3F4038403F;
            6'h38: r = 40'h6314081463;
            6'h39: r = 40'h0304780403;
            6'h3A: r = 40'h6159494D43;
            6'h3B: r = 40'h007F414141;
            6'h3C: r = 40'h0204081020;
            6'h3D: r = 40'h004141417F;
            6'h3E: r = 40'h0402010204;
            6'h3F: r = 40'h4040404040;
            default: r = 40'h0000000000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] font_col(
        input logic [7:0] code,
        input logic [2:0] col
    );
        logic        is_lc;
        logic        is_fn;
        logic [39:0] row;
        logic [7:0]  px;
        is_lc = (code >= 8'h61) && (code <= 8'h7A);
        is_fn = (code >= 8'h20) && (code <= 8'h5F);
        row = 40'h0;
        unique case (1'b1)
            is_lc:   row = font_row({1'b1, code[4:0]});
            is_fn:   row = font_row({~code[5], code[4:0]});
            default: row = 40'h0;
        endcase
        case (col)
            3'd0:    px = row[39:32];
            3'd1:    px = row[31:24];
            3'd2:    px = row[23:16];
            3'd3:    px = row[15:8];
            3'd4:    px = row[7:0];
            default: px = 8'h00;
        endcase
        return px;
    endfunction

    // text buffer: host writes land any time, reset clears to spaces
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                text_buf[i] <= 8'h20;
            end
        end else if (wr_en && ({1'b0, wr_addr} < SLOTS)) begin
            text_buf[wr_addr] <= wr_data;
        end
    end

    // state and stream position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            char_idx <= '0;
            col_idx  <= '0;
            char_reg <= 8'h20;
            inv_reg  <= 1'b0;
        end else begin
            state    <= state_nx;
            char_idx <= char_idx_nx;
            col_idx  <= col_idx_nx;
            char_reg <= char_nx;
            inv_reg  <= inv_nx;
        end
    end

    // next-state, handshake and status outputs
    always_comb begin
        state_nx    = state;
        char_idx_nx = char_idx;
        col_idx_nx  = col_idx;
        char_nx     = char_reg;
        inv_nx      = inv_reg;
        col_valid   = 1'b0;
        col_last    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx    = LOAD;
                    char_idx_nx = '0;
                    col_idx_nx  = '0;
                    inv_nx      = invert;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                char_nx  = text_buf[char_idx];
                state_nx = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                col_valid = 1'b1;
                col_last  = (char_idx == CHAR_END) &&
                            (col_idx == COL_END);
                if (col_ready) begin
                    if (col_idx == COL_END) begin
                        col_idx_nx = '0;
                        if (char_idx == CHAR_END) begin
                            state_nx = DONE;
                        end else begin
                            char_idx_nx = char_idx + 1'b1;
                            state_nx    = LOAD;
                        end
                    end else begin
                        col_idx_nx = col_idx + 3'd1;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // column pixels depend only on registered state, so they hold under stall
    always_comb begin
        glyph    = font_col(char_reg, col_idx);
        col_data = 8'h00;
        if (state == STREAM) begin
            col_data = glyph ^ {8{inv_reg}};
        end
    end

endmodule

// File: tb/tb_text_column_streamer.sv
// tb_text_column_streamer: table-driven lines plus hand sequences,
// columns checked against a scoreboard queue at each handshake.
module tb_text_column_streamer;

    localparam int NC = 4;
    localparam int GW = 1;
    localparam int LINE_COLS = NC * (5 + GW);

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       invert;
    logic [7:0] col_data;
    logic       col_valid;
    logic       col_ready;
    logic       col_last;
    logic       busy;
    logic       done;

    text_column_streamer #(
        .NUM_CHARS(NC),
        .GAP_W(GW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .invert(invert),
        .col_data(col_data),
        .col_valid(col_valid),
        .col_ready(col_ready),
        .col_last(col_last),
        .busy(busy),
        .done(done)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } col_t;

    typedef struct {
        logic [7:0]  code;
        logic [39:0] cols;
    } gl_t;

    typedef struct {
        logic        rst_first;
        logic [3:0]  wmask;
        logic [31:0] text;
        logic        inv;
        logic        stall;
    } line_t;

    col_t        sb[$];
    gl_t         gtab[14];
    line_t       lines[6];
    int          checks = 0;
    int          failures = 0;
    int          acc_cnt = 0;
    logic        rnd_mode = 1'b0;
    logic        ready_hold = 1'b1;
    logic [31:0] mdl_text = 32'h20202020;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] glyph_of(input logic [7:0] c);
        logic [39:0] g = 40'h0;
        for (int i = 0; i < 14; i++) begin
            if (gtab[i].code == c) g = gtab[i].cols;
        end
        return g;
    endfunction

    task automatic push_line(input logic [31:0] t, input logic inv);
        logic [39:0] g;
        col_t        e;
        for (int c = 0; c < NC; c++) begin
            g = glyph_of(t[31-8*c -: 8]);
            for (int k = 0; k < 5 + GW; k++) begin
                e.d = (k < 5) ? g[39-8*k -: 8] : 8'h00;
                if (inv) e.d = ~e.d;
                e.l = (c == NC - 1) && (k == 4 + GW);
                sb.push_back(e);
            end
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        mdl_text[31-8*a -: 8] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        mdl_text = 32'h20202020;
    endtask

    task automatic wait_done(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk(nm, 32'(got), 32'd1);
    endtask

    task automatic run_line(input string nm);
        acc_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, "_busy_load"}, 32'(busy), 32'd1);
        chk({nm, "_valid_load"}, 32'(col_valid), 32'd0);
        tick();
        chk({nm, "_first_valid"}, 32'(col_valid), 32'd1);
        wait_done({nm, "_done"});
        chk({nm, "_cols"}, 32'(acc_cnt), 32'(LINE_COLS));
        chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            col_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_hold;
        end
    end

    initial begin : monitor
        logic       stalled = 1'b0;
        logic       done_nx = 1'b0;
        logic [7:0] prev_d = 8'h00;
        logic       prev_l = 1'b0;
        col_t       e;
        forever begin
            @(negedge clk);
            if (done_nx) chk("done_after_last", 32'(done), 32'd1);
            done_nx = 1'b0;
            if (stalled) begin
                chk("stall_valid_held", 32'(col_valid), 32'd1);
                chk("stall_data_held", 32'(col_data), 32'(prev_d));
                chk("stall_last_held", 32'(col_last), 32'(prev_l));
            end
            if (col_valid && col_ready) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_col", 32'(col_data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("col_data", 32'(col_data), 32'(e.d));
                    chk("col_last", 32'(col_last), 32'(e.l));
                    done_nx = e.l;
                end
            end
            stalled = col_valid && !col_ready;
            prev_d  = col_data;
            prev_l  = col_last;
        end
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        invert  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'h00;

        gtab[0]  = '{8'h48, 40'h7F0808087F};
        gtab[1]  = '{8'h45, 40'h7F49494941};
        gtab[2]  = '{8'h4C, 40'h7F40404040};
        gtab[3]  = '{8'h4F, 40'h3E4141413E};
        gtab[4]  = '{8'h6F, 40'h3E4141413E};
        gtab[5]  = '{8'h7E, 40'h0000000000};
        gtab[6]  = '{8'h20, 40'h0000000000};
        gtab[7]  = '{8'h41, 40'h7C1211127C};
        gtab[8]  = '{8'h7A, 40'h6159494D43};
        gtab[9]  = '{8'h30, 40'h3E5149453E};
        gtab[10] = '{8'h21, 40'h00005F0000};
        gtab[11] = '{8'h5F, 40'h4040404040};
        gtab[12] = '{8'h68, 40'h7F0808087F};
        gtab[13] = '{8'h5A, 40'h6159494D43};

        lines[0] = '{1'b0, 4'hF, "HELO", 1'b0, 1'b0};
        lines[1] = '{1'b0, 4'h0, "HELO", 1'b1, 1'b0};
        lines[2] = '{1'b0, 4'h0, "HELO", 1'b0, 1'b1};
        lines[3] = '{1'b1, 4'h3, 32'h6F7E_0000, 1'b0, 1'b0};
        lines[4] = '{1'b0, 4'hF, "Az0!", 1'b1, 1'b1};
        lines[5] = '{1'b0, 4'hF, 32'h5F60_7B68, 1'b0, 1'b0};

        tick();
        tick();
        chk("rst_valid", 32'(col_valid), 32'd0);
        chk("rst_last", 32'(col_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(col_data), 32'd0);
        rst = 1'b0;
        tick();

        for (int n = 0; n < 6; n++) begin
            if (lines[n].rst_first) do_reset();
            for (int s = 0; s < NC; s++) begin
                if (lines[n].wmask[s]) begin
                    wr(2'(s), lines[n].text[31-8*s -: 8]);
                end
            end
            rnd_mode = lines[n].stall;
            invert   = lines[n].inv;
            push_line(mdl_text, lines[n].inv);
            run_line($sformatf("line%0d", n));
            invert   = 1'b0;
            rnd_mode = 1'b0;
            tick();
        end

        push_line(mdl_text, 1'b0);
        acc_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && acc_cnt < 10; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("midstart_busy", 32'(busy), 32'd1);
        wait_done("midstart_done");
        chk("midstart_cols", 32'(acc_cnt), 32'(LINE_COLS));
        start = 1'b1;
        tick();
        chk("donestart_ignored", 32'(busy), 32'd0);
        chk("donestart_valid", 32'(col_valid), 32'd0);
        tick();
        start = 1'b0;
        chk("idlestart_taken", 32'(busy), 32'd1);
        push_line(mdl_text, 1'b0);
        acc_cnt = 0;
        wait_done("idlestart_done");
        chk("idlestart_cols", 32'(acc_cnt), 32'(LINE_COLS));
        tick();

        wr(2'd0, "H");
        wr(2'd1, "E");
        wr(2'd2, "L");
        wr(2'd3, "O");
        push_line(mdl_text, 1'b0);
        acc_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && acc_cnt < 7; i++) tick();
        rst = 1'b1;
        tick();
        chk("abort_valid", 32'(col_valid), 32'd0);
        chk("abort_data", 32'(col_data), 32'd0);
        chk("abort_last", 32'(col_last), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        rst = 1'b0;
        sb.delete();
        mdl_text = 32'h20202020;
        tick();
        chk("abort_no_done", 32'(done), 32'd0);
        push_line(mdl_text, 1'b0);
        run_line("spaces");
        tick();

        wr(2'd0, "H");
        wr(2'd1, "E");
        wr(2'd2, "L");
        wr(2'd3, "O");
        push_line({"HEL", 8'h5A}, 1'b0);
        acc_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wr(2'd0, "A");
        wr(2'd3, "Z");
        wait_done("livewr_done");
        chk("livewr_cols", 32'(acc_cnt), 32'(LINE_COLS));
        tick();
        push_line(mdl_text, 1'b0);
        run_line("livewr_next");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
